// File: rtl/tl_ul_sram_responder_if.sv
// tl_ul_sram_responder_if: single-beat 64-bit TileLink-UL A/D channel pair.
interface tl_ul_sram_responder_if #(parameter int SOURCE_BITS = 4);
  logic                   a_valid;
  logic                   a_ready;
  logic [2:0]             a_opcode;
  logic [2:0]             a_param;
  logic [2:0]             a_size;
  logic [SOURCE_BITS-1:0] a_source;
  logic [31:0]            a_address;
  logic [7:0]             a_mask;
  logic [63:0]            a_data;
  logic                   d_valid;
  logic                   d_ready;
  logic [2:0]             d_opcode;
  logic [2:0]             d_param;
  logic [2:0]             d_size;
  logic [SOURCE_BITS-1:0] d_source;
  logic [63:0]            d_data;
  logic                   d_denied;
  logic                   d_corrupt;
  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_data, d_denied, d_corrupt
  );
  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_data, d_denied, d_corrupt
  );
endinterface

// File: rtl/tl_ul_sram_responder.sv
// tl_ul_sram_responder: TL-UL slave executing Get/Put (and LogicalData when
// TL_RESP_LOGICAL_EN is defined) against a local word array, one D register.
module tl_ul_sram_responder #(
  parameter logic [31:0] BASE        = 32'h0800_0000,
  parameter int          DEPTH       = 64,
  parameter int          SOURCE_BITS = 4
) (
  input logic                 clock,
  input logic                 reset,
  tl_ul_sram_responder_if.slave tl
);
`ifdef TL_RESP_LOGICAL_EN
  localparam bit LOGICAL_EN = 1'b1;
`else
  localparam bit LOGICAL_EN = 1'b0;
`endif
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(DEPTH * 8);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e                 state_q, state_d;
  logic [63:0]            mem_q [DEPTH];
  logic [2:0]             d_opcode_q, d_opcode_d, d_size_q, d_size_d;
  logic [SOURCE_BITS-1:0] d_source_q, d_source_d;
  logic [63:0]            d_data_q, d_data_d;
  logic                   d_denied_q, d_denied_d, d_corrupt_q, d_corrupt_d;
  logic                   fire, in_range, aligned, is_put, is_get, is_logical, legal, we;
  logic [2:0]             size_mask;
  logic [AW-1:0]          idx;
  logic [63:0]            old_w, alu, wdata;
  assign tl.a_ready = !reset && (state_q == EMPTY || tl.d_ready);
  assign fire       = tl.a_valid && tl.a_ready;
  assign idx        = tl.a_address[3 +: AW];
  assign old_w      = mem_q[idx];
  always_comb begin
    in_range   = {1'b0, tl.a_address} >= {1'b0, BASE} && {1'b0, tl.a_address} < LIMIT;
    size_mask  = 3'((4'd1 << tl.a_size[1:0]) - 4'd1);
    aligned    = (tl.a_address[2:0] & size_mask) == 3'd0;
    is_put     = tl.a_opcode == 3'd0 || tl.a_opcode == 3'd1;
    is_get     = tl.a_opcode == 3'd4;
    is_logical = LOGICAL_EN && tl.a_opcode == 3'd3 && !tl.a_param[2];
    legal      = in_range && !tl.a_size[2] && aligned && (is_put || is_get || is_logical);
    alu        = tl.a_param[1:0] == 2'd0 ? old_w ^ tl.a_data :
                 tl.a_param[1:0] == 2'd1 ? old_w | tl.a_data :
                 tl.a_param[1:0] == 2'd2 ? old_w & tl.a_data : tl.a_data;
    wdata      = is_put ? tl.a_data : alu;
    we         = fire && legal && !is_get;
  end
  // Read of old_w and the masked write share one edge: single-cycle RMW.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 8; i++)
      if (we && tl.a_mask[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  always_comb begin
    state_d     = state_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_data_d    = d_data_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    if (fire) begin
      state_d     = FULL;
      d_opcode_d  = {2'b00, !is_put};
      d_size_d    = tl.a_size;
      d_source_d  = tl.a_source;
      d_data_d    = legal && !is_put ? old_w : 64'd0;
      d_denied_d  = !legal;
      d_corrupt_d = !legal && !is_put;
    end else if (tl.d_ready) begin
      state_d     = EMPTY;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_data_q    <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_data_q    <= d_data_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
    end
  end
  assign tl.d_valid   = state_q == FULL;
  assign tl.d_opcode  = d_opcode_q;
  assign tl.d_param   = 3'd0;
  assign tl.d_size    = d_size_q;
  assign tl.d_source  = d_source_q;
  assign tl.d_data    = d_data_q;
  assign tl.d_denied  = d_denied_q;
  assign tl.d_corrupt = d_corrupt_q;
endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// tb_tl_ul_sram_responder: random + directed TL-UL traffic, queue scoreboard
// against a word-array reference model.
module tb_tl_ul_sram_responder;
  localparam logic [31:0] BASE  = 32'h0800_0000;
  localparam int          DEPTH = 64;
  localparam int          SB    = 4;
`ifdef TL_RESP_LOGICAL_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif
  typedef struct packed {
    logic [2:0]    op;
    logic [2:0]    size;
    logic [SB-1:0] src;
    logic [63:0]   data;
    logic          den;
    logic          cor;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tl_ul_sram_responder_if #(.SOURCE_BITS(SB)) tl();
  tl_ul_sram_responder #(.BASE(BASE), .DEPTH(DEPTH), .SOURCE_BITS(SB)) dut (
    .clock(clk), .reset(rst), .tl(tl.slave)
  );
  exp_t        q[$];
  logic [63:0] ref_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  bit          rnd_rdy = 1'b0;
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] op, input logic [2:0] par, input logic [2:0] size,
                                 input logic [SB-1:0] src, input logic [31:0] addr,
                                 input logic [7:0] mask, input logic [63:0] data);
    exp_t e;
    logic [63:0] old, nw;
    int idx;
    bit inr, ok, isput, islog;
    inr   = addr >= BASE && (addr - BASE) < DEPTH * 8;
    isput = op == 3'd0 || op == 3'd1;
    islog = LOG && op == 3'd3 && par < 3'd4;
    ok    = inr && size <= 3'd3 && (addr % (32'd1 << size)) == 0 && (isput || op == 3'd4 || islog);
    idx   = inr ? int'((addr - BASE) / 8) : 0;
    old   = ref_mem[idx];
    e.op   = isput ? 3'd0 : 3'd1;
    e.size = size;
    e.src  = src;
    e.den  = !ok;
    e.cor  = !ok && !isput;
    e.data = (ok && !isput) ? old : 64'd0;
    if (ok && (isput || islog)) begin
      nw = isput ? data : par == 3'd0 ? old ^ data : par == 3'd1 ? old | data :
           par == 3'd2 ? old & data : data;
      for (int i = 0; i < 8; i++) if (mask[i]) ref_mem[idx][8*i +: 8] = nw[8*i +: 8];
    end
    return e;
  endfunction
  task automatic send(input logic [2:0] op, input logic [2:0] par, input logic [2:0] size,
                      input logic [SB-1:0] src, input logic [31:0] addr,
                      input logic [7:0] mask, input logic [63:0] data);
    tl.a_valid = 1'b1; tl.a_opcode = op; tl.a_param = par; tl.a_size = size;
    tl.a_source = src; tl.a_address = addr; tl.a_mask = mask; tl.a_data = data;
    if (rnd_rdy) tl.d_ready = $urandom_range(0, 3) != 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tl.a_ready) begin
        q.push_back(model(op, par, size, src, addr, mask, data));
        @(posedge clk); #1;
        tl.a_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rnd_rdy) tl.d_ready = $urandom_range(0, 3) != 0;
    end
    checks++; errors++;
    $display("FAIL a_ready_timeout: got 0 expected 1 within 200 cycles");
    tl.a_valid = 1'b0;
  endtask
  function automatic exp_t cur();
    exp_t c;
    c.op = tl.d_opcode; c.size = tl.d_size; c.src = tl.d_source;
    c.data = tl.d_data; c.den = tl.d_denied; c.cor = tl.d_corrupt;
    return c;
  endfunction
  bit   pend = 1'b0;
  bit   hold = 1'b0;
  exp_t snap;
  always @(negedge clk) begin
    if (rst) begin
      chk("a_ready_in_reset", 80'(tl.a_ready), 80'd0);
      pend = 1'b0;
      hold = 1'b0;
    end else begin
      if (pend) chk("d_valid_after_fire", 80'(tl.d_valid), 80'd1);
      if (hold) chk("d_stable_stall", 80'(cur()), 80'(snap));
      chk("a_ready_rule", 80'(tl.a_ready), 80'(!tl.d_valid || tl.d_ready));
      if (tl.d_valid) chk("d_param", 80'(tl.d_param), 80'd0);
      if (tl.d_valid && tl.d_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got %0h expected none", cur());
        end else begin
          chk("d_response", 80'(cur()), 80'(q.pop_front()));
        end
      end
      hold = tl.d_valid && !tl.d_ready;
      snap = cur();
      pend = tl.a_valid && tl.a_ready;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    tl.a_valid = 1'b0; tl.a_opcode = '0; tl.a_param = '0; tl.a_size = '0;
    tl.a_source = '0; tl.a_address = '0; tl.a_mask = '0; tl.a_data = '0;
    tl.d_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_d_valid", 80'(tl.d_valid), 80'd0);
    chk("reset_d_fields", 80'(cur()), 80'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(3'd0, 3'd0, 3'd3, 4'd0, BASE + 8 * i, 8'hFF, {$urandom, $urandom});
    send(3'd0, 3'd0, 3'd3, 4'd3, BASE + 8, 8'hFF, 64'h1122334455667788);
    send(3'd4, 3'd0, 3'd3, 4'd5, BASE + 8, 8'h00, 64'd0);
    send(3'd1, 3'd0, 3'd3, 4'd1, BASE + 8, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    send(3'd4, 3'd0, 3'd3, 4'd2, BASE + 8, 8'hFF, 64'd0);
    repeat (2) @(posedge clk); #1;
    tl.d_ready = 1'b0;
    send(3'd4, 3'd0, 3'd3, 4'd6, BASE + 16, 8'hFF, 64'd0);
    tl.a_valid = 1'b1; tl.a_opcode = 3'd4; tl.a_address = BASE + 8; tl.a_source = 4'd7;
    repeat (5) begin
      @(negedge clk);
      chk("a_ready_stall", 80'(tl.a_ready), 80'd0);
    end
    @(posedge clk); #1;
    tl.d_ready = 1'b1;
    #1 chk("a_ready_release", 80'(tl.a_ready), 80'd1);
    send(3'd4, 3'd0, 3'd3, 4'd7, BASE + 8, 8'hFF, 64'd0);
    send(3'd4, 3'd0, 3'd3, 4'd1, BASE + DEPTH * 8, 8'hFF, 64'd0);
    send(3'd4, 3'd0, 3'd2, 4'd2, BASE + 2, 8'hFF, 64'd0);
    send(3'd0, 3'd0, 3'd4, 4'd3, BASE + 24, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
    send(3'd0, 3'd0, 3'd3, 4'd4, BASE - 8, 8'hFF, 64'd1);
    send(3'd2, 3'd0, 3'd3, 4'd5, BASE + 24, 8'hFF, 64'd2);
    for (int o = 5; o < 8; o++) send(3'(o), 3'd0, 3'd3, 4'(o), BASE + 24, 8'hFF, 64'd3);
    send(3'd4, 3'd0, 3'd3, 4'd9, BASE + 24, 8'hFF, 64'd0);
    send(3'd0, 3'd0, 3'd3, 4'd0, BASE + 32, 8'hFF, 64'hF0F0);
    send(3'd3, 3'd0, 3'd3, 4'd1, BASE + 32, 8'hFF, 64'h0FF0);
    send(3'd4, 3'd0, 3'd3, 4'd2, BASE + 32, 8'hFF, 64'd0);
    send(3'd3, 3'd3, 3'd3, 4'd3, BASE + 32, 8'hFF, 64'd5);
    send(3'd4, 3'd0, 3'd3, 4'd4, BASE + 32, 8'hFF, 64'd0);
    send(3'd3, 3'd5, 3'd3, 4'd5, BASE + 32, 8'hFF, 64'hFFFF);
    send(3'd4, 3'd0, 3'd3, 4'd6, BASE + 32, 8'hFF, 64'd0);
    repeat (2) @(posedge clk); #1;
    tl.d_ready = 1'b0;
    send(3'd4, 3'd0, 3'd3, 4'd8, BASE + 40, 8'hFF, 64'd0);
    rst = 1'b1; tl.d_ready = 1'b1;
    tl.a_valid = 1'b1; tl.a_opcode = 3'd0; tl.a_size = 3'd3; tl.a_address = BASE + 40;
    tl.a_mask = 8'hFF; tl.a_data = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    rst = 1'b0; tl.a_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("d_valid_after_reset", 80'(tl.d_valid), 80'd0);
    @(posedge clk); #1;
    send(3'd4, 3'd0, 3'd3, 4'd9, BASE + 40, 8'hFF, 64'd0);
    rnd_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  op, par, sz;
      logic [31:0] ad;
      int          r;
      r   = int'($urandom_range(0, 9));
      op  = r < 3 ? 3'd0 : r < 5 ? 3'd1 : r < 8 ? 3'd4 : r == 8 ? 3'd3 : 3'($urandom_range(0, 7));
      par = $urandom_range(0, 3) == 0 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      sz  = $urandom_range(0, 4) == 0 ? 3'($urandom_range(0, 7)) : 3'd3;
      ad  = BASE + 8 * $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 5) == 0) ad = ad + $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0)
        ad = $urandom_range(0, 3) == 0 ? BASE - 8 : BASE + DEPTH * 8 + 8 * $urandom_range(0, 3);
      send(op, par, sz, 4'($urandom), ad, 8'($urandom), {$urandom, $urandom});
    end
    rnd_rdy = 1'b0;
    tl.d_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("queue_drained", 80'(q.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tl_ul_sram_responder.md
Name: tl_ul_sram_responder

Overview:
- TileLink-UL responder (slave end) for a single-beat, 64-bit A/D channel pair: accepts A-channel Get/PutFullData/PutPartialData, executes them against a local 64-bit-wide register-array memory, and returns AccessAck/AccessAckData on the D channel.
- Terminates a pass-through TL link inside the core complex; used as a scratch/test memory behind a crossbar port.

Parameters:
- BASE, 32'h0800_0000, byte base address of the memory window; DEPTH*8-aligned.
- DEPTH, 64, number of 64-bit words; power of two, 2..1024.
- SOURCE_BITS, 4, width of a_source/d_source.

Ports:
- clock  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  A request valid.
- a_ready  out  1  A request accepted when a_valid&&a_ready.
- a_opcode  in  3  0 PutFull, 1 PutPartial, 3 LogicalData (macro), 4 Get.
- a_param  in  3  logical op select (macro only); else ignored.
- a_size  in  3  log2 bytes, legal 0..3.
- a_source  in  SOURCE_BITS  request ID.
- a_address  in  32  byte address.
- a_mask  in  8  byte lanes.
- a_data  in  64  write/operand data.
- d_valid  out  1  response valid.
- d_ready  in  1  response accepted when d_valid&&d_ready.
- d_opcode  out  3  0 AccessAck, 1 AccessAckData.
- d_param  out  3  always 0.
- d_size  out  3  echo of a_size.
- d_source  out  SOURCE_BITS  echo of a_source.
- d_data  out  64  read data (old data for atomics).
- d_denied  out  1  request rejected.
- d_corrupt  out  1  d_data invalid; set iff d_denied on data responses.

Behaviour:
- Reset: d_valid=0; d_opcode/d_param/d_size/d_source/d_data/d_denied/d_corrupt=0; memory contents not reset. Reset mid-response drops the pending response; no write from the cycle reset is high.
- Single-entry D output register; states EMPTY (d_valid=0) and FULL (d_valid=1).
- a_ready = !d_valid || d_ready (combinational from d_ready); reset forces a_ready=0.
- A fire in cycle N -> d_valid=1 in cycle N+1 with all d_* fields registered; full throughput of one request per cycle while d_ready=1.
- FULL && !d_ready: hold all d_* stable, a_ready=0.
- Index = a_address[3 +: log2(DEPTH)].
- Legal iff: BASE <= address < BASE+DEPTH*8; size<=3; address aligned to 2^size; opcode supported.
- Get: d_opcode=1, d_data = mem[index] read at fire (full 64 bits, mask ignored).
- PutFull/PutPartial: mem[index] byte lanes with a_mask[i]=1 written at fire edge; d_opcode=0, d_data=0.
- Write at fire N is visible to a Get firing at N+1 (no stale read).
- Illegal: no memory write; d_denied=1; d_opcode=1 with d_corrupt=1 and d_data=0 for Get/LogicalData/unknown opcodes; d_opcode=0, d_corrupt=0 for Puts.
- Opcode 2 (ArithmeticData) and opcodes 5..7 are always illegal.

Optional Feature:
- TL_RESP_LOGICAL_EN defined: opcode 3 LogicalData supported. param 0 XOR, 1 OR, 2 AND, 3 SWAP; param 4..7 illegal. At fire, d_data = old mem[index]; new = op(old, a_data) written on masked lanes in the same edge; d_opcode=1. Single-cycle RMW, no extra latency.
- Not defined: opcode 3 treated as illegal (denied, corrupt, no write).

Test Plan:
- Reset then PutFull addr BASE+8, mask FF, data 64'h1122334455667788, source 3 -> next cycle d_valid, opcode 0, source 3, denied 0; following Get BASE+8 size 3 -> opcode 1, data 64'h1122334455667788.
- PutPartial BASE+8 mask 8'h0F data 64'hAAAAAAAA_BBBBBBBB back-to-back with Get BASE+8 -> Get data 64'h11223344_BBBBBBBB, one response per cycle.
- d_ready=0 for 5 cycles after a Get -> d_* stable, a_ready=0 throughout; d_ready=1 -> a_ready=1 same cycle, next request accepted.
- Get BASE+DEPTH*8, then Get BASE+2 size 2 (misaligned), then Put size 4 -> each d_denied=1; Gets d_corrupt=1 and data 0; Put response opcode 0; memory unchanged on read-back.
- With TL_RESP_LOGICAL_EN: mem=64'hF0F0, LogicalData param 0 data 64'h0FF0 mask FF -> d_data 64'hF0F0, read-back 64'hFF00; param 3 data 5 -> d_data 64'hFF00, read-back 5. Without macro: same request -> denied, corrupt, memory unchanged.
- Assert reset while d_valid=1 and a_valid=1 with a Put -> d_valid=0 next cycle, target word unchanged on subsequent Get.
